// File: rtl/wavegen_pkg.sv
// Shared constants and types for the test-waveform sequencer.
// Wave codes, FSM state encoding and default field widths.
package wavegen_pkg;

  localparam int WIDTH_D = 8;
  localparam int DIV_W_D = 8;
  localparam int CNT_W_D = 16;

  localparam logic [2:0] WAVE_SAW = 3'd0;
  localparam logic [2:0] WAVE_REV = 3'd1;
  localparam logic [2:0] WAVE_TRI = 3'd2;
  localparam logic [2:0] WAVE_M50 = 3'd3;
  localparam logic [2:0] WAVE_M25 = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic wave_ok(input logic [2:0] w);
    return w <= WAVE_M25;
  endfunction

endpackage

// File: rtl/wavegen_sequencer_wave_shaper.sv
// Combinational waveform shaper: maps (wave, phase) to one sample.
// Reserved codes yield zero; callers filter them before use.
module wave_shaper
  import wavegen_pkg::*;
#(
  parameter int WIDTH = WIDTH_D
) (
  input  logic [2:0]       i_wave,
  input  logic [WIDTH-1:0] i_phase,
  output logic [WIDTH-1:0] o_sample
);

  always_comb begin
    o_sample = '0;
    unique case (i_wave)
      WAVE_SAW: o_sample = i_phase;
      WAVE_REV: o_sample = -i_phase;
      WAVE_TRI: o_sample = i_phase[WIDTH-1] ? ~i_phase : i_phase;
      WAVE_M50: o_sample = i_phase[WIDTH-1] ? '0 : '1;
      WAVE_M25: o_sample = (i_phase[WIDTH-1 -: 2] == 2'b00) ? '1 : '0;
      default:  o_sample = '0;
    endcase
  end

endmodule

// File: rtl/wavegen_sequencer.sv
// Command-driven sequencer: plays N periods of a selected waveform
// at a programmed step rate, with stop/abort and completion pulse.
module wavegen_sequencer
  import wavegen_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DIV_W = DIV_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_wave,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [CNT_W-1:0] cmd_periods,
  input  logic             stop,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] P_ONE = WIDTH'(1);
  localparam logic [DIV_W-1:0] D_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t           r_state;
  logic [2:0]       r_wave;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_periods;
  logic [WIDTH-1:0] r_phase;
  logic [DIV_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_period_cnt;
  logic [WIDTH-1:0] r_sample;
  logic             r_sample_valid;
  logic             r_done;
  logic             r_err;

  logic             w_idle;
  logic [WIDTH-1:0] w_phase_nxt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic [2:0]       w_sh_wave;
  logic [WIDTH-1:0] w_sh_phase;
  logic [WIDTH-1:0] w_shape;
  logic             w_period_end;
  logic             w_last;

  assign w_idle       = (r_state == IDLE);
  assign w_phase_nxt  = r_phase + P_ONE;
  assign w_pcnt_nxt   = r_period_cnt + C_ONE;
  assign w_period_end = (r_phase == '1);
  assign w_last       = w_period_end && (r_periods != '0)
                        && (w_pcnt_nxt == r_periods);

  // One shaper serves both the first sample on accept and each step.
  assign w_sh_wave  = w_idle ? cmd_wave : r_wave;
  assign w_sh_phase = w_idle ? '0 : w_phase_nxt;

  wave_shaper #(.WIDTH(WIDTH)) u_shaper (
    .i_wave   (w_sh_wave),
    .i_phase  (w_sh_phase),
    .o_sample (w_shape)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_wave         <= '0;
      r_div          <= '0;
      r_periods      <= '0;
      r_phase        <= '0;
      r_div_cnt      <= '0;
      r_period_cnt   <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_sample_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (wave_ok(cmd_wave)) begin
              r_wave         <= cmd_wave;
              r_div          <= cmd_div;
              r_periods      <= cmd_periods;
              r_phase        <= '0;
              r_div_cnt      <= '0;
              r_period_cnt   <= '0;
              r_sample       <= w_shape;
              r_sample_valid <= 1'b1;
              r_state        <= RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            r_state  <= IDLE;
            r_sample <= '0;
          end else if (r_div_cnt != r_div) begin
            r_div_cnt <= r_div_cnt + D_ONE;
          end else begin
            r_div_cnt <= '0;
            r_phase   <= w_phase_nxt;
            if (w_period_end)
              r_period_cnt <= w_pcnt_nxt;
            if (w_last) begin
              r_state  <= IDLE;
              r_done   <= 1'b1;
              r_sample <= '0;
            end else begin
              r_sample       <= w_shape;
              r_sample_valid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = w_idle;
  assign busy         = (r_state == RUN);
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign done         = r_done;
  assign err          = r_err;

endmodule
